// File: rtl/striping_n_pkg.sv
// -----------------------------------------------------------------------------
// striping_n_pkg
//   Definitions shared by the striping and un-striping blocks:
//   the architectural lane limit, the reset level, and a helper that returns
//   the low bit of lane i on a flattened NUM_LANES*W bus.
// -----------------------------------------------------------------------------
package striping_n_pkg;

    localparam int   MAX_LANES = 8;     // largest lane count either block supports
    localparam logic RST_LVL   = 1'b0;  // reset input is active-low

    // Low bit of lane i on a flattened bus: bus[lane_lo(i, W) +: W]
    function automatic int lane_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/striping_lane_reg.sv
// -----------------------------------------------------------------------------
// striping_lane_reg
//   One lane's output register: the data word is loaded on write enable and
//   held otherwise; valid is a one-cycle pulse that follows the write enable.
// Ports
//   clk_i    clock, rising edge
//   rst_ni   asynchronous reset, active-low
//   we_i     load data_i this cycle
//   data_i   word to store
//   data_o   stored word (held between writes)
//   valid_o  pulses for one cycle after each write
// -----------------------------------------------------------------------------
module striping_lane_reg
    import striping_n_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q;

    always_comb begin
        data_d = data_q;
        if (we_i) data_d = data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RST_LVL) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= we_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/striping_n.sv
// -----------------------------------------------------------------------------
// striping_n
//   Distributes accepted words round-robin over a run-time selectable number
//   of lanes. One word per clk_2f cycle, one cycle of latency.
// Ports
//   clk_2f        clock, rising edge
//   reset         asynchronous reset, active-low
//   data_in       input word
//   valid_in      data_in valid this cycle
//   lanes_active  requested active lane count, 1..NUM_LANES
//   restart       synchronous realign of the pointer to lane 0
//   lane_data     flattened lane words, lane i = [i*DATA_W +: DATA_W]
//   lane_valid    one-hot (or zero) per-lane valid pulse
//   lane_ptr      lane that the next accepted word targets
//   stripe_done   pulse: the last active lane was written this cycle
//   cfg_err       sticky: an illegal lanes_active value was sampled
// -----------------------------------------------------------------------------
module striping_n
    import striping_n_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                        clk_2f,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        valid_in,
    input  logic [LANE_W:0]             lanes_active,
    input  logic                        restart,
    output logic [NUM_LANES*DATA_W-1:0] lane_data,
    output logic [NUM_LANES-1:0]        lane_valid,
    output logic [LANE_W-1:0]           lane_ptr,
    output logic                        stripe_done,
    output logic                        cfg_err
);

    if (NUM_LANES < 2 || NUM_LANES > MAX_LANES) begin : g_bad_lanes
        $error("striping_n: NUM_LANES must be 2..%0d", MAX_LANES);
    end

    localparam logic [LANE_W:0] NL = (LANE_W+1)'(NUM_LANES);

    logic [LANE_W-1:0]    ptr_q, ptr_d;
    logic [LANE_W:0]      cfg_q, cfg_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;

    logic                 sample;
    logic                 legal;
    logic [LANE_W:0]      eff_n;
    logic [LANE_W-1:0]    wr_ptr;
    logic                 last;
    logic [NUM_LANES-1:0] we;

    // Configuration is only taken at an idle stripe boundary or on restart,
    // so a stripe in flight always completes with the count it started with.
    assign sample = (ptr_q == '0 && !valid_in) || restart;
    assign legal  = (lanes_active != '0) && (lanes_active <= NL);

    always_comb begin
        cfg_d = cfg_q;
        err_d = err_q;
        if (sample) begin
            cfg_d = legal ? lanes_active : NL;
            err_d = err_q | ~legal;
        end
    end

    // A word accepted together with restart targets lane 0 and must already
    // see the freshly sampled lane count.
    assign eff_n  = sample ? cfg_d : cfg_q;
    assign wr_ptr = restart ? '0 : ptr_q;
    assign last   = ({1'b0, wr_ptr} == eff_n - (LANE_W+1)'(1));

    always_comb begin
        ptr_d  = wr_ptr;
        done_d = 1'b0;
        if (valid_in) begin
            ptr_d  = last ? '0 : wr_ptr + LANE_W'(1);
            done_d = last;
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (reset == RST_LVL) begin
            ptr_q  <= '0;
            cfg_q  <= NL;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cfg_q  <= cfg_d;
            err_q  <= err_d;
            done_q <= done_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign we[i] = valid_in && (wr_ptr == LANE_W'(i));

        striping_lane_reg #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk_i   (clk_2f),
            .rst_ni  (reset),
            .we_i    (we[i]),
            .data_i  (data_in),
            .data_o  (lane_data[lane_lo(i, DATA_W) +: DATA_W]),
            .valid_o (lane_valid[i])
        );
    end

    assign lane_ptr    = ptr_q;
    assign stripe_done = done_q;
    assign cfg_err     = err_q;

endmodule
